// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store access controller: funct3 encodings,
// FSM states, response error codes and the request classifier.
package lsu_pkg;

    localparam int WORD_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10
    } err_e;

    // Illegal takes priority over misaligned: a bad opcode says nothing
    // meaningful about alignment.
    function automatic err_e classify(input logic       rd,
                                      input logic       wr,
                                      input logic [2:0] f3,
                                      input logic [1:0] off);
        err_e e;
        e = ERR_NONE;
        if (rd == wr)
            e = ERR_ILLEGAL;
        else if (rd && !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
            e = ERR_ILLEGAL;
        else if (wr && !(f3 inside {F3_B, F3_H, F3_W}))
            e = ERR_ILLEGAL;
        else if ((f3 == F3_H || f3 == F3_HU) && off[0])
            e = ERR_MISALIGN;
        else if (f3 == F3_W && off != 2'b00)
            e = ERR_MISALIGN;
        return e;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane selection for sub-word accesses: extracts and extends load data from a
// memory word, and builds the merged word for byte/halfword stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] store_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte/halfword and extend or merge it.
    always_comb begin
        lane_b     = word[{offset, 3'b000} +: 8];
        lane_h     = offset[1] ? word[31:16] : word[15:0];
        load_data  = word;
        store_word = wdata;

        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'h0, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'h0, lane_h};
            default: load_data = word;
        endcase

        case (funct3)
            F3_B: begin
                store_word = word;
                store_word[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H:    store_word = offset[1] ? {wdata[15:0], word[15:0]}
                                            : {word[31:16], wdata[15:0]};
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Load/store access controller in front of the data memory. Every access is
// issued as a full word; SB/SH become read-modify-write.
//
// state | meaning
// IDLE  | ready for a request; classify on accept
// RD    | one-cycle word read; loads extract, SB/SH build merged word
// WR    | one-cycle word write
// RESP  | hold response until the consumer takes it
module lsu_access_ctrl
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic [1:0]            resp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_e              state;
    logic [1:0]          off_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [2:0]          f3_q;
    logic                is_store;
    err_e                req_err;
    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   store_word;
    logic [DM_ADDRESS-1:0] word_addr;

    // Memory only ever sees full-word LW/SW.
    assign mem_funct3 = F3_W;
    assign word_addr  = {req_addr[DM_ADDRESS-1:2], 2'b00};

    // Classify the incoming request before it is accepted.
    always_comb begin
        req_err = classify(req_read, req_write, req_funct3, req_addr[1:0]);
    end

    // Lane logic works straight on the memory word arriving at the end of RD,
    // so the merged store word is ready to be registered into mem_wdata.
    lsu_align u_align (
        .word       (mem_rdata),
        .offset     (off_q),
        .funct3     (f3_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Sequencing FSM; every output is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= ERR_NONE;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            is_store   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        f3_q      <= req_funct3;
                        is_store  <= req_write;
                        req_ready <= 1'b0;
                        if (req_err != ERR_NONE) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= req_err;
                        end else if (req_write && req_funct3 == F3_W) begin
                            state     <= WR;
                            mem_write <= 1'b1;
                            mem_addr  <= word_addr;
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= RD;
                            mem_read <= 1'b1;
                            mem_addr <= word_addr;
                        end
                    end
                end
                RD: begin
                    mem_read <= 1'b0;
                    if (is_store) begin
                        state     <= WR;
                        mem_write <= 1'b1;
                        mem_wdata <= store_word;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                        resp_err   <= ERR_NONE;
                    end
                end
                WR: begin
                    mem_write  <= 1'b0;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_err   <= ERR_NONE;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= ERR_NONE;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Bench for lsu_access_ctrl: behavioural word memory, vector table with a
// response scoreboard, plus stall and mid-write reset sequences.
module tb_lsu_access_ctrl;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_read;
    logic        req_write;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;

    logic [31:0] tbmem [0:127];
    int          n_rd;
    int          n_wr;
    logic        both_seen;
    int          n_cmp;
    int          n_bad;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_err;
        int          exp_lat;
        int          exp_nrd;
        int          exp_nwr;
        int          mem_idx;
        logic [31:0] exp_mem;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } resp_t;

    vec_t  vecs [$];
    resp_t sb_q [$];

    lsu_access_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_funct3 (mem_funct3),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = tbmem[mem_addr[8:2]];

    // Data memory: preset contents, then write on a mem_write cycle.
    initial begin
        for (int i = 0; i < 128; i++) tbmem[i] = 32'h0;
        tbmem[0] = 32'h8000_80F0;
        tbmem[4] = 32'h1122_3344;
        tbmem[6] = 32'hCAFE_F00D;
        tbmem[7] = 32'h0102_0304;
        forever begin
            @(posedge clk);
            if (mem_write) tbmem[mem_addr[8:2]] <= mem_wdata;
        end
    end

    // Count memory pulses and watch for read/write overlap.
    initial begin
        n_rd = 0;
        n_wr = 0;
        both_seen = 1'b0;
        forever begin
            @(posedge clk);
            if (mem_read)  n_rd++;
            if (mem_write) n_wr++;
            if (mem_read && mem_write) both_seen = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_resp(input string name);
        resp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_sb: got response with empty scoreboard expected queued entry", name);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_rdata"}, resp_rdata, e.rdata);
            chk({name, "_err"}, {30'h0, resp_err}, {30'h0, e.err});
        end
    endtask

    function automatic void add(input string name, input logic rd, input logic wr,
                                input logic [8:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, input logic [31:0] exp_rdata,
                                input logic [1:0] exp_err, input int lat, input int nrd,
                                input int nwr, input int midx, input logic [31:0] emem);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.f3 = f3;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = lat;
        v.exp_nrd = nrd; v.exp_nwr = nwr; v.mem_idx = midx; v.exp_mem = emem;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [8:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
        req_valid  = 1'b1;
        req_read   = rd;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
    endtask

    task automatic idle_inputs();
        req_valid  = 1'b0;
        req_read   = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int rd0;
        int wr0;
        resp_t e;
        @(negedge clk);
        chk({v.name, "_ready"}, {31'h0, req_ready}, 32'd1);
        drive(v.rd, v.wr, v.addr, v.wdata, v.f3);
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb_q.push_back(e);
        rd0 = n_rd;
        wr0 = n_wr;
        @(posedge clk); #1;
        idle_inputs();
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({v.name, "_lat"}, lat, v.exp_lat);
        check_resp(v.name);
        @(posedge clk); #1;
        chk({v.name, "_nrd"}, n_rd - rd0, v.exp_nrd);
        chk({v.name, "_nwr"}, n_wr - wr0, v.exp_nwr);
        if (v.mem_idx >= 0)
            chk({v.name, "_mem"}, tbmem[v.mem_idx], v.exp_mem);
    endtask

    initial begin
        int lat;
        logic [31:0] w7;
        resp_t e;
        n_cmp = 0;
        n_bad = 0;

        //  name           rd wr addr    wdata         f3     rdata         err    lat rd wr midx mem
        add("lb_neg",      1, 0, 9'h000, 32'h0,        F3_B,  32'hFFFF_FFF0, 2'b00, 2, 1, 0, -1, 32'h0);
        add("lbu",         1, 0, 9'h000, 32'h0,        F3_BU, 32'h0000_00F0, 2'b00, 2, 1, 0, -1, 32'h0);
        add("lh_neg",      1, 0, 9'h002, 32'h0,        F3_H,  32'hFFFF_8000, 2'b00, 2, 1, 0, -1, 32'h0);
        add("lhu",         1, 0, 9'h002, 32'h0,        F3_HU, 32'h0000_8000, 2'b00, 2, 1, 0, -1, 32'h0);
        add("lw",          1, 0, 9'h000, 32'h0,        F3_W,  32'h8000_80F0, 2'b00, 2, 1, 0, -1, 32'h0);
        add("sb_l1",       0, 1, 9'h011, 32'h0000_00AB, F3_B, 32'h0,         2'b00, 3, 1, 1,  4, 32'h1122_AB44);
        add("lw_after_sb", 1, 0, 9'h010, 32'h0,        F3_W,  32'h1122_AB44, 2'b00, 2, 1, 0, -1, 32'h0);
        add("sw_restore",  0, 1, 9'h010, 32'h1122_3344, F3_W, 32'h0,         2'b00, 2, 0, 1,  4, 32'h1122_3344);
        add("sh_hi",       0, 1, 9'h012, 32'h0000_BEEF, F3_H, 32'h0,         2'b00, 3, 1, 1,  4, 32'hBEEF_3344);
        add("lb_l3",       1, 0, 9'h013, 32'h0,        F3_B,  32'hFFFF_FFBE, 2'b00, 2, 1, 0, -1, 32'h0);
        add("lbu_l1",      1, 0, 9'h011, 32'h0,        F3_BU, 32'h0000_0033, 2'b00, 2, 1, 0, -1, 32'h0);
        add("lhu_lo",      1, 0, 9'h010, 32'h0,        F3_HU, 32'h0000_3344, 2'b00, 2, 1, 0, -1, 32'h0);
        add("sw",          0, 1, 9'h014, 32'hDEAD_BEEF, F3_W, 32'h0,         2'b00, 2, 0, 1,  5, 32'hDEAD_BEEF);
        add("sb_l0",       0, 1, 9'h014, 32'hFFFF_FF55, F3_B, 32'h0,         2'b00, 3, 1, 1,  5, 32'hDEAD_BE55);
        add("lw_w5",       1, 0, 9'h014, 32'h0,        F3_W,  32'hDEAD_BE55, 2'b00, 2, 1, 0, -1, 32'h0);
        add("lh_hi",       1, 0, 9'h016, 32'h0,        F3_H,  32'hFFFF_DEAD, 2'b00, 2, 1, 0, -1, 32'h0);
        add("sh_lo",       0, 1, 9'h014, 32'hABCD_5678, F3_H, 32'h0,         2'b00, 3, 1, 1,  5, 32'hDEAD_5678);
        add("lw_mis",      1, 0, 9'h006, 32'h0,        F3_W,  32'h0,         2'b01, 1, 0, 0, -1, 32'h0);
        add("sh_mis",      0, 1, 9'h003, 32'h0000_1234, F3_H, 32'h0,         2'b01, 1, 0, 0,  0, 32'h8000_80F0);
        add("lh_mis",      1, 0, 9'h001, 32'h0,        F3_H,  32'h0,         2'b01, 1, 0, 0, -1, 32'h0);
        add("lhu_mis",     1, 0, 9'h013, 32'h0,        F3_HU, 32'h0,         2'b01, 1, 0, 0, -1, 32'h0);
        add("sw_mis",      0, 1, 9'h012, 32'h5555_5555, F3_W, 32'h0,         2'b01, 1, 0, 0,  4, 32'hBEEF_3344);
        add("rd_and_wr",   1, 1, 9'h000, 32'h0,        F3_W,  32'h0,         2'b10, 1, 0, 0, -1, 32'h0);
        add("no_op",       0, 0, 9'h000, 32'h0,        F3_W,  32'h0,         2'b10, 1, 0, 0, -1, 32'h0);
        add("ld_f3_011",   1, 0, 9'h000, 32'h0,        3'b011, 32'h0,        2'b10, 1, 0, 0, -1, 32'h0);
        add("ld_f3_110",   1, 0, 9'h000, 32'h0,        3'b110, 32'h0,        2'b10, 1, 0, 0, -1, 32'h0);
        add("st_f3_100",   0, 1, 9'h000, 32'h0,        3'b100, 32'h0,        2'b10, 1, 0, 0,  0, 32'h8000_80F0);

        rst_n      = 1'b0;
        resp_ready = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready",  {31'h0, req_ready},  32'd1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata,          32'h0);
        chk("rst_resp_err",   {30'h0, resp_err},   32'h0);
        chk("rst_mem_read",   {31'h0, mem_read},   32'd0);
        chk("rst_mem_write",  {31'h0, mem_write},  32'd0);
        chk("rst_mem_addr",   {23'h0, mem_addr},   32'h0);
        chk("rst_mem_wdata",  mem_wdata,           32'h0);
        chk("mem_funct3",     {29'h0, mem_funct3}, 32'd2);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Consumer stalls on an SB response; then a request queued during the
        // stall is accepted the cycle after the handshake.
        @(negedge clk);
        resp_ready = 1'b0;
        drive(1'b0, 1'b1, 9'h018, 32'h0000_0077, F3_B);
        e.rdata = 32'h0; e.err = 2'b00;
        sb_q.push_back(e);
        @(posedge clk); #1;
        idle_inputs();
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("stall_sb_lat", lat, 3);
        check_resp("stall_sb");
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'h0, resp_valid}, 32'd1);
            chk("stall_rdata", resp_rdata, 32'h0);
            chk("stall_err",   {30'h0, resp_err}, 32'h0);
            chk("stall_ready", {31'h0, req_ready}, 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        drive(1'b1, 1'b0, 9'h018, 32'h0, F3_W);
        e.rdata = 32'hCAFE_F077; e.err = 2'b00;
        sb_q.push_back(e);
        @(posedge clk); #1;
        chk("post_hs_valid", {31'h0, resp_valid}, 32'd0);
        chk("post_hs_ready", {31'h0, req_ready},  32'd1);
        chk("stall_mem",     tbmem[6], 32'hCAFE_F077);
        @(posedge clk); #1;
        idle_inputs();
        chk("b2b_accepted", {31'h0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_lw_valid", {31'h0, resp_valid}, 32'd1);
        check_resp("b2b_lw");
        @(posedge clk); #1;

        // Reset lands while an SB is in its write cycle.
        w7 = tbmem[7];
        @(negedge clk);
        drive(1'b0, 1'b1, 9'h01D, 32'h0000_0099, F3_B);
        @(posedge clk); #1;
        idle_inputs();
        chk("rst_seq_rd", {31'h0, mem_read}, 32'd1);
        @(posedge clk); #1;
        chk("rst_seq_wr", {31'h0, mem_write}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_wr_drop", {31'h0, mem_write},  32'd0);
        chk("rst_async_valid",   {31'h0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_after_ready", {31'h0, req_ready},  32'd1);
        chk("rst_after_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_word_whole",
            {31'h0, (tbmem[7] == w7) || (tbmem[7] == 32'h0102_9904)}, 32'd1);
        sb_q.delete();
        begin
            vec_t v;
            v.name = "lw_after_rst"; v.rd = 1'b1; v.wr = 1'b0; v.addr = 9'h01C;
            v.wdata = 32'h0; v.f3 = F3_W; v.exp_rdata = tbmem[7]; v.exp_err = 2'b00;
            v.exp_lat = 2; v.exp_nrd = 1; v.exp_nwr = 0; v.mem_idx = -1; v.exp_mem = 32'h0;
            run_vec(v);
        end

        chk("no_rd_wr_overlap", {31'h0, both_seen}, 32'd0);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_access_ctrl.md
Name: lsu_access_ctrl

Overview:
- Load/store access controller sitting directly upstream of the data memory; takes one memory request per handshake from the pipeline MEM stage.
- Turns every access into word-aligned full-word memory operations.
- Implements SB/SH as read-modify-write sequences and returns sign- or zero-extended load data.
- Flags misaligned and illegal requests without touching memory.

Parameters:
- DM_ADDRESS, 9, byte-address width presented to data memory.
- DATA_W, 32, data width; block supports 32 only.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_read  in  1  load request.
- req_write  in  1  store request.
- req_addr  in  DM_ADDRESS  byte address.
- req_wdata  in  DATA_W  store data, LSB-justified.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 illegal.
- mem_read  out  1  drives data memory MemRead.
- mem_write  out  1  drives data memory MemWrite.
- mem_addr  out  DM_ADDRESS  word address, {req_addr[8:2],2'b00}.
- mem_wdata  out  DATA_W  full word to write.
- mem_funct3  out  3  constant 3'b010; memory always sees LW/SW.
- mem_rdata  in  DATA_W  memory read word; valid at the rising edge ending a mem_read cycle.

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=00, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; all internal latches cleared.
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid && req_ready, latch addr, wdata, funct3 and op, then classify:
  - illegal → RESP with err=10: req_read==req_write, or a load funct3 outside {000,001,010,100,101}, or a store funct3 outside {000,001,010}.
  - misaligned → RESP with err=01: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
  - load or SB/SH → RD.
  - SW → WR.
- RD: mem_read=1 for one cycle. Capture mem_rdata into word register at the closing edge. Loads go to RESP; SB/SH go to WR.
- WR: mem_write=1 for one cycle.
  - SW: mem_wdata=wdata.
  - SB: captured word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: captured word with halfword lane addr[1] replaced by wdata[15:0].
  - Next state RESP.
- RESP: resp_valid=1; resp_rdata and resp_err held stable until resp_ready=1, then IDLE. req_ready=0 throughout.
- Load extraction:
  - LB: sign-extend byte lane addr[1:0].
  - LBU: zero-extend byte lane addr[1:0].
  - LH: sign-extend halfword lane addr[1].
  - LHU: zero-extend halfword lane addr[1].
  - LW: full word.
- mem_read and mem_write are never both 1; both are 0 outside RD/WR. mem_addr is held constant from RD through WR.
- Latency, accept edge to first resp_valid cycle (resp_ready=1): error 1, load 2, SW 2, SB/SH 3 cycles. Throughput is one request in flight.
- Back-to-back: a new request is accepted in the IDLE cycle immediately following the RESP handshake; there is no bubble beyond that.
- Reset mid-operation: immediate return to IDLE, in-flight response discarded, mem_write drops asynchronously. The target word holds either the old value or the complete new merged value, never a partial merge.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Package lsu_pkg:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - state enum: IDLE/RD/WR/RESP.
  - resp_err codes: ERR_NONE, ERR_MISALIGN, ERR_ILLEGAL.
- Sub-module lsu_align (combinational): given word, byte offset and funct3, produces extended load data and merged store word. It is the only place lane selection lives.

Test Plan:
- Memory word 0x0 = 0x8000_80F0; LB addr 0x000 → resp_rdata=0xFFFF_FFF0 at accept+2; LBU addr 0x000 → 0x0000_00F0; LH addr 0x002 → 0xFFFF_8000; LHU addr 0x002 → 0x0000_8000.
- Word 0x10 = 0x1122_3344; SB addr 0x011 wdata=0xAB → one mem_read then one mem_write of 0x1122_AB44 at 0x010; resp at accept+3 with err=00; subsequent LW 0x010 returns 0x1122_AB44.
- SH addr 0x012 wdata=0xBEEF over 0x1122_3344 → memory 0xBEEF_3344. SW addr 0x014 wdata=0xDEAD_BEEF → single write, no mem_read, resp at accept+2.
- LW addr 0x006 → err=01 at accept+1, no mem_read/mem_write pulses. SH addr 0x003 → err=01. req_read=req_write=1 → err=10. Load funct3=011 → err=10.
- resp_ready held 0 for 4 cycles after SB response → resp_valid, rdata and err stable, req_ready=0. On release, the next request is accepted the following cycle.
- rst_n asserted during WR of an SB → mem_write falls immediately; after release req_ready=1, resp_valid=0; target word reads either old or fully merged value.
